// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps at most one imem read in flight and holds the returned
// word in a one-entry valid/ready buffer for the decoder. Optional HALT stop: FETCH_HALT_EN.
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              id_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted
);
    localparam logic [31:0] NOP_WORD = 32'h0320_0000;

`ifdef FETCH_HALT_EN
    localparam logic [31:0] HALT_WORD = 32'h0100_0000;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN, S_HALTED} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN} state_t;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_out;
    logic [31:0]       r_instr;
    logic              r_valid;
`ifdef FETCH_HALT_EN
    logic              r_halted;
`endif

    logic              w_issue;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;

    // A request may only go out when the buffer is empty or being emptied this cycle,
    // so a returning word always has somewhere to land.
    assign w_issue  = (r_state == S_FETCH) & (~r_valid | id_ready);
    assign w_xfer   = r_valid & id_ready;
    assign w_pc_inc = r_pc + ADDR_W'(4);
    assign w_target = branch_target & ~(ADDR_W'(3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_pc_out <= RESET_PC;
            r_instr  <= NOP_WORD;
            r_valid  <= 1'b0;
`ifdef FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else if (flush) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
            // A request already on the bus must still be retired, its data thrown away.
            // DRAIN leaves as soon as that response shows up, even under a repeated flush.
            case (r_state)
                S_WAIT:  r_state <= imem_rvalid ? S_FETCH : S_DRAIN;
                S_DRAIN: r_state <= imem_rvalid ? S_FETCH : S_DRAIN;
                S_FETCH: r_state <= w_issue ? S_DRAIN : S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            if (w_xfer) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_instr  <= imem_rdata;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_pc     <= w_pc_inc;
                        r_state  <= S_FETCH;
`ifdef FETCH_HALT_EN
                        if (imem_rdata == HALT_WORD) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end
`endif
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_valid;
`ifdef FETCH_HALT_EN
    assign halted      = r_halted;
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: latency-configurable imem model plus scoreboards of
// expected request addresses and expected decoder transfers.
module tb_instr_fetch;
    localparam logic [31:0] NOP       = 32'h0320_0000;
    localparam logic [31:0] HALT      = 32'h0100_0000;
    localparam logic [31:0] HALT_ADDR = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        id_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halted;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 1;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] exp_req[$];
    logic [63:0] exp_xfer[$];

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .id_ready(id_ready), .flush(flush), .branch_target(branch_target),
        .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE081_0002;
        if (a == HALT_ADDR) return HALT;
        return 32'h1300_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        #1;
        while (!imem_req && n < 30) begin nxt(); #1; n++; end
        chk(tag, imem_req, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        #1;
        while (!instr_valid && n < 30) begin nxt(); #1; n++; end
        chk(tag, instr_valid, 1);
    endtask

    // Memory answers mem_lat cycles after the request cycle, regardless of reset/flush.
    always @(negedge clk) begin
        if (imem_req) begin
            m_cnt  <= mem_lat;
            m_addr <= imem_addr;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
        imem_rvalid <= (m_cnt == 1);
        imem_rdata  <= word(m_addr);
    end

    always @(negedge clk) begin
        if (rst_n && imem_req) begin
            if (exp_req.size() == 0) chk("req_unexpected", {32'h0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("req_addr", {32'h0, imem_addr}, {32'h0, exp_req.pop_front()});
        end
        if (rst_n && instr_valid && id_ready && !flush) begin
            if (exp_xfer.size() == 0) chk("xfer_unexpected", {pc_out, instr_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("xfer_data", {pc_out, instr_out}, exp_xfer.pop_front());
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_halted", halted, 0);
        exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
        exp_xfer.push_back({32'h0, 32'hE081_0002});
        exp_xfer.push_back({32'h4, word(32'h4)});
        nxt(); nxt(); rst_n = 1'b1;

        // 1: first fetch and its two-cycle latency
        wait_req("t1_req");
        chk("t1_addr", imem_addr, 32'h0);
        nxt(); #1; chk("t1_lat_n1", instr_valid, 0);
        nxt(); #1;
        chk("t1_valid", instr_valid, 1);
        chk("t1_instr", instr_out, 32'hE081_0002);
        chk("t1_pc_out", pc_out, 32'h0);
        chk("t1_stall_noreq", imem_req, 0);
        id_ready = 1'b1; #1;
        chk("t1_next_req", imem_req, 1);
        chk("t1_next_addr", imem_addr, 32'h4);
        nxt(); id_ready = 1'b0;

        // 2: decoder back-pressure
        wait_valid("t2_valid");
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_instr", instr_out, word(32'h4));
            chk("t2_hold_pc", pc_out, 32'h4);
            chk("t2_hold_valid", instr_valid, 1);
            chk("t2_no_req", imem_req, 0);
            nxt(); #1;
        end
        id_ready = 1'b1; #1;
        chk("t2_req", imem_req, 1);
        chk("t2_addr", imem_addr, 32'h8);
        nxt(); id_ready = 1'b0;

        // 3: flush while a slow response is outstanding
        exp_xfer.push_back({32'h8, word(32'h8)});
        exp_req.push_back(32'hC); exp_req.push_back(32'h100);
        wait_valid("t3_buf");
        chk("t3_pc8", pc_out, 32'h8);
        mem_lat = 3; id_ready = 1'b1; #1;
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 32'hC);
        nxt(); id_ready = 1'b0; flush = 1'b1; branch_target = 32'h103; #1;
        chk("t3_flush_noreq", imem_req, 0);
        nxt(); flush = 1'b0; #1;
        chk("t3_drop_v1", instr_valid, 0);
        chk("t3_drain_noreq1", imem_req, 0);
        nxt(); #1;
        chk("t3_drop_v2", instr_valid, 0);
        chk("t3_drain_noreq2", imem_req, 0);
        nxt(); #1;
        chk("t3_drop_v3", instr_valid, 0);
        chk("t3_redir_req", imem_req, 1);
        chk("t3_redir_addr", imem_addr, 32'h100);
        exp_xfer.push_back({32'h100, word(32'h100)});
        nxt(); mem_lat = 1;
        wait_valid("t3_valid");
        chk("t3_pc_out", pc_out, 32'h100);
        chk("t3_instr", instr_out, word(32'h100));

        // 4: flush in the same cycle as the response
        exp_req.push_back(32'h104); exp_req.push_back(32'h40);
        id_ready = 1'b1; #1;
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h104);
        nxt(); id_ready = 1'b0; flush = 1'b1; branch_target = 32'h40;
        nxt(); flush = 1'b0; #1;
        chk("t4_discard", instr_valid, 0);
        chk("t4_redir_req", imem_req, 1);
        chk("t4_redir_addr", imem_addr, 32'h40);
        nxt();
        wait_valid("t4_valid");
        chk("t4_pc_out", pc_out, 32'h40);
        chk("t4_instr", instr_out, word(32'h40));

        // 5: HALT word; flush with a full buffer voids the buffered word
        exp_req.push_back(HALT_ADDR);
        exp_xfer.push_back({HALT_ADDR, HALT});
        flush = 1'b1; branch_target = HALT_ADDR; #1;
        chk("t5_flush_noreq", imem_req, 0);
        nxt(); flush = 1'b0; #1;
        chk("t5_void", instr_valid, 0);
        chk("t5_req", imem_req, 1);
        chk("t5_addr", imem_addr, HALT_ADDR);
        nxt();
        wait_valid("t5_valid");
        chk("t5_pc_out", pc_out, HALT_ADDR);
        chk("t5_instr", instr_out, HALT);
`ifdef FETCH_HALT_EN
        nxt(); id_ready = 1'b1; #1;
        for (int i = 0; i < 10; i++) begin
            chk("t5_halted", halted, 1);
            chk("t5_halt_noreq", imem_req, 0);
            nxt(); #1;
        end
        id_ready = 1'b0;
`else
        chk("t5_not_halted", halted, 0);
        exp_req.push_back(HALT_ADDR + 32'h4);
        id_ready = 1'b1; #1;
        chk("t5_next_req", imem_req, 1);
        chk("t5_next_addr", imem_addr, HALT_ADDR + 32'h4);
        nxt(); id_ready = 1'b0;
        wait_valid("t5_next_valid");
        chk("t5_next_pc", pc_out, HALT_ADDR + 32'h4);
        chk("t5_not_halted2", halted, 0);
`endif
        exp_req.push_back(32'h20);
        mem_lat = 2;
        flush = 1'b1; branch_target = 32'h20; #1;
        chk("t5_flush2_noreq", imem_req, 0);
        nxt(); flush = 1'b0; #1;
        chk("t5_unhalt", halted, 0);
        chk("t5_redir_req", imem_req, 1);
        chk("t5_redir_addr", imem_addr, 32'h20);

        // 6: reset during WAIT, late response ignored, then PC wrap
        exp_req.push_back(32'h0);
        nxt(); rst_n = 1'b0; #1;
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_valid", instr_valid, 0);
        chk("t6_rst_instr", instr_out, NOP);
        chk("t6_rst_pc_out", pc_out, 32'h0);
        chk("t6_rst_halted", halted, 0);
        nxt(); rst_n = 1'b1; mem_lat = 1; #1;
        chk("t6_idle_noreq", imem_req, 0);
        chk("t6_stale_v0", instr_valid, 0);
        nxt(); #1;
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_stale_v1", instr_valid, 0);
        nxt(); #1;
        chk("t6_lat_v", instr_valid, 0);
        nxt(); #1;
        chk("t6_valid", instr_valid, 1);
        chk("t6_pc_out", pc_out, 32'h0);
        chk("t6_instr", instr_out, 32'hE081_0002);

        exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0); exp_req.push_back(32'h4);
        exp_xfer.push_back({32'hFFFF_FFFC, word(32'hFFFF_FFFC)});
        exp_xfer.push_back({32'h0, 32'hE081_0002});
        flush = 1'b1; branch_target = 32'hFFFF_FFFF;
        nxt(); flush = 1'b0; #1;
        chk("t6_top_req", imem_req, 1);
        chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
        nxt();
        wait_valid("t6_top_valid");
        chk("t6_top_pc", pc_out, 32'hFFFF_FFFC);
        id_ready = 1'b1; #1;
        chk("t6_wrap_req", imem_req, 1);
        chk("t6_wrap_addr", imem_addr, 32'h0);
        nxt(); id_ready = 1'b0;
        wait_valid("t6_wrap_valid");
        chk("t6_wrap_pc", pc_out, 32'h0);
        chk("t6_wrap_instr", instr_out, 32'hE081_0002);
        id_ready = 1'b1; #1;
        chk("t6_after_wrap_addr", imem_addr, 32'h4);
        nxt(); id_ready = 1'b0;
        repeat (4) nxt();

        chk("sb_req_empty", exp_req.size(), 0);
        chk("sb_xfer_empty", exp_xfer.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
